// File: rtl/mem_responder_pkg.sv
// Shared parameters for the core memory responder: geometry, loader FSM
// encoding and the core's opcode set.
package mem_responder_pkg;

  localparam int MEM_DEPTH = 32;
  localparam int MEM_WIDTH = 16;
  localparam int ADDR_W    = 5;
  localparam int WL_W      = 6;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    RUN     = 2'd2
  } ld_state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_JMP   = 4'h5,
    OP_BEQ   = 4'h6,
    OP_HALT  = 4'hF
  } opcode_e;

endpackage

// File: rtl/mem_responder.sv
// Program memory with a byte-serial image loader; once the image is in, the
// core owns the memory and the loader is locked out until reset.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int WIDTH = MEM_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_write_data,
  input  logic              mem_write,
  output logic [WIDTH-1:0]  mem_read_data,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              start_execution,
  output logic [WL_W-1:0]   words_loaded,
  output logic              load_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ld_state_e        state_q;
  logic [7:0]       lo_q;
  logic [WL_W-1:0]  wl_q;
  logic             err_q, ready_q, start_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept, last_word;
  logic             wr_en_d;
  logic [IDX_W-1:0] wr_idx_d;
  logic [WIDTH-1:0] wr_data_d;

  assign accept    = load_valid && ready_q;
  assign last_word = (wl_q == WL_W'(DEPTH - 1));

  // Single memory write port, shared by loader and core by FSM state.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = '0;
    wr_data_d = '0;
    unique case (state_q)
      LOAD_LO: if (accept && load_last) begin
        wr_en_d   = 1'b1;
        wr_idx_d  = wl_q[IDX_W-1:0];
        wr_data_d = WIDTH'(load_byte);
      end
      LOAD_HI: if (accept) begin
        wr_en_d   = 1'b1;
        wr_idx_d  = wl_q[IDX_W-1:0];
        wr_data_d = WIDTH'({load_byte, lo_q});
      end
      RUN: if (mem_write && (int'(mem_addr) < DEPTH)) begin
        wr_en_d   = 1'b1;
        wr_idx_d  = IDX_W'(mem_addr);
        wr_data_d = mem_write_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_LO;
      lo_q    <= '0;
      wl_q    <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD_LO: if (accept) begin
          if (load_last) begin
            // Image ended on a low byte: store it zero-extended and flag it.
            wl_q    <= wl_q + 1'b1;
            err_q   <= 1'b1;
            state_q <= RUN;
            ready_q <= 1'b0;
            start_q <= 1'b1;
          end else begin
            lo_q    <= load_byte;
            state_q <= LOAD_HI;
          end
        end
        LOAD_HI: if (accept) begin
          wl_q <= wl_q + 1'b1;
          if (load_last || last_word) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            start_q <= 1'b1;
          end else begin
            state_q <= LOAD_LO;
          end
        end
        RUN: ;
        default: begin
          state_q <= LOAD_LO;
          ready_q <= 1'b1;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_d) begin
      mem_q[wr_idx_d] <= wr_data_d;
    end
  end

  assign mem_read_data   = (int'(mem_addr) < DEPTH) ? mem_q[IDX_W'(mem_addr)] : '0;
  assign load_ready      = ready_q;
  assign start_execution = start_q;
  assign words_loaded    = wl_q;
  assign load_error      = err_q;

endmodule
